// File: rtl/wb_target_arbiter.sv
// Round-robin arbiter that shares one Wishbone target among N initiators.
// The grant is locked for the bus cycle, and a watchdog aborts transfers the target never acknowledges.
module wb_target_arbiter #(
    parameter  int N_INITIATORS   = 2,
    parameter  int TIMEOUT_CYCLES = 255,
    parameter  int CNT_WIDTH      = 8,
    localparam int IDX_W          = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_INITIATORS-1:0] req,
    input  logic [N_INITIATORS-1:0] cyc_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    to_clr,
    output logic [N_INITIATORS-1:0] gnt,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    tgt_en,
    output logic                    to_err,
    output logic                    to_flag,
    output logic [IDX_W-1:0]        to_idx
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_ABORT    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam bit                   WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                    state_q, state_d;
    logic [N_INITIATORS-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
    logic                      tgt_en_q, tgt_en_d;
    logic                      to_err_q, to_err_d;
    logic                      to_flag_q, to_flag_d;
    logic [IDX_W-1:0]          to_idx_q, to_idx_d;
    logic [IDX_W-1:0]          last_q, last_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic                      win_valid_s;
    logic [IDX_W-1:0]          win_idx_s;
    logic [IDX_W-1:0]          cand_s;
    logic                      owner_cyc_s;
    logic                      to_set_s;

    assign owner_cyc_s = cyc_i[gnt_idx_q];

    // Round-robin search: first requester after the last owner, wrapping.
    always_comb begin
        win_valid_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= N_INITIATORS; k++) begin
            cand_s = IDX_W'((int'(last_q) + k) % N_INITIATORS);
            if (!win_valid_s && req[cand_s]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Next-state and registered-output computation for the ownership FSM.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        tgt_en_d  = tgt_en_q;
        to_idx_d  = to_idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        to_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    gnt_d            = '0;
                    gnt_d[win_idx_s] = 1'b1;
                    gnt_idx_d        = win_idx_s;
                    last_d           = win_idx_s;
                    tgt_en_d         = 1'b1;
                    cnt_d            = '0;
                    state_d          = ST_BUSY;
                end else begin
                    gnt_d    = '0;
                    tgt_en_d = 1'b0;
                end
            end
            ST_BUSY: begin
                // Priority: owner release, then target response, then watchdog expiry.
                if (!owner_cyc_s) begin
                    gnt_d    = '0;
                    tgt_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (ack_i || err_i) begin
                    cnt_d = '0;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    tgt_en_d = 1'b0;
                    to_set_s = 1'b1;
                    to_idx_d = gnt_idx_q;
                    state_d  = ST_ABORT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ABORT: begin
                tgt_en_d = 1'b0;
                state_d  = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                tgt_en_d = 1'b0;
                if (!owner_cyc_s) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                gnt_d    = '0;
                tgt_en_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Timeout strobe and sticky flag; a new timeout beats a simultaneous clear.
    always_comb begin
        to_err_d = to_set_s;
        if (to_set_s) begin
            to_flag_d = 1'b1;
        end else if (to_clr) begin
            to_flag_d = 1'b0;
        end else begin
            to_flag_d = to_flag_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            tgt_en_q  <= 1'b0;
            to_err_q  <= 1'b0;
            to_flag_q <= 1'b0;
            to_idx_q  <= '0;
            last_q    <= IDX_W'(N_INITIATORS - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            tgt_en_q  <= tgt_en_d;
            to_err_q  <= to_err_d;
            to_flag_q <= to_flag_d;
            to_idx_q  <= to_idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign tgt_en  = tgt_en_q;
    assign to_err  = to_err_q;
    assign to_flag = to_flag_q;
    assign to_idx  = to_idx_q;

endmodule

// File: tb/tb_wb_target_arbiter.sv
// Directed bench for wb_target_arbiter with N=2 and an 8-cycle watchdog.
module tb_wb_target_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] req;
    logic [1:0] cyc_i;
    logic       ack_i;
    logic       err_i;
    logic       to_clr;
    logic [1:0] gnt;
    logic [0:0] gnt_idx;
    logic       tgt_en;
    logic       to_err;
    logic       to_flag;
    logic [0:0] to_idx;

    int n_checks = 0;
    int n_pass   = 0;

    wb_target_arbiter #(
        .N_INITIATORS  (2),
        .TIMEOUT_CYCLES(8),
        .CNT_WIDTH     (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .cyc_i  (cyc_i),
        .ack_i  (ack_i),
        .err_i  (err_i),
        .to_clr (to_clr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .tgt_en (tgt_en),
        .to_err (to_err),
        .to_flag(to_flag),
        .to_idx (to_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 2'b00; cyc_i = 2'b00; ack_i = 1'b0; err_i = 1'b0; to_clr = 1'b0;
        tick(); tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b exp 00", gnt); else n_pass++;
        n_checks++; if (tgt_en !== 1'b0) $display("FAIL reset_tgt_en got %b exp 0", tgt_en); else n_pass++;
        n_checks++; if (to_err !== 1'b0) $display("FAIL reset_to_err got %b exp 0", to_err); else n_pass++;
        n_checks++; if (to_flag !== 1'b0) $display("FAIL reset_to_flag got %b exp 0", to_flag); else n_pass++;
        n_checks++; if (to_idx !== 1'b0) $display("FAIL reset_to_idx got %b exp 0", to_idx); else n_pass++;
        n_checks++; if (gnt_idx !== 1'b0) $display("FAIL reset_gnt_idx got %b exp 0", gnt_idx); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_first_grant();
        req = 2'b11; cyc_i = 2'b11;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL first_gnt got %b exp 01", gnt); else n_pass++;
        n_checks++; if (gnt_idx !== 1'b0) $display("FAIL first_gnt_idx got %b exp 0", gnt_idx); else n_pass++;
        n_checks++; if (tgt_en !== 1'b1) $display("FAIL first_tgt_en got %b exp 1", tgt_en); else n_pass++;
    endtask

    task automatic test_fairness();
        cyc_i = 2'b10;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL fair_dead1_gnt got %b exp 00", gnt); else n_pass++;
        n_checks++; if (tgt_en !== 1'b0) $display("FAIL fair_dead1_tgt_en got %b exp 0", tgt_en); else n_pass++;
        cyc_i = 2'b11;
        tick();
        n_checks++; if (gnt !== 2'b10) $display("FAIL fair_gnt1 got %b exp 10", gnt); else n_pass++;
        n_checks++; if (gnt_idx !== 1'b1) $display("FAIL fair_gnt_idx1 got %b exp 1", gnt_idx); else n_pass++;
        cyc_i = 2'b01;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL fair_dead2_gnt got %b exp 00", gnt); else n_pass++;
        cyc_i = 2'b11;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL fair_gnt0 got %b exp 01", gnt); else n_pass++;
        n_checks++; if (gnt_idx !== 1'b0) $display("FAIL fair_gnt_idx0 got %b exp 0", gnt_idx); else n_pass++;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 20; i++) begin
            ack_i = ((i % 3) == 2);
            tick();
            n_checks++; if (gnt !== 2'b01) $display("FAIL lock_gnt[%0d] got %b exp 01", i, gnt); else n_pass++;
            n_checks++; if (to_err !== 1'b0) $display("FAIL lock_to_err[%0d] got %b exp 0", i, to_err); else n_pass++;
        end
        ack_i = 1'b0; req = 2'b00; cyc_i = 2'b00;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL lock_release_gnt got %b exp 00", gnt); else n_pass++;
    endtask

    task automatic test_timeout();
        req = 2'b01; cyc_i = 2'b01;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL to_grant_gnt got %b exp 01", gnt); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++; if (to_err !== 1'b0) $display("FAIL to_early_err[%0d] got %b exp 0", k, to_err); else n_pass++;
            n_checks++; if (tgt_en !== 1'b1) $display("FAIL to_early_tgt_en[%0d] got %b exp 1", k, tgt_en); else n_pass++;
        end
        tick();
        n_checks++; if (to_err !== 1'b1) $display("FAIL to_err got %b exp 1", to_err); else n_pass++;
        n_checks++; if (tgt_en !== 1'b0) $display("FAIL to_tgt_en got %b exp 0", tgt_en); else n_pass++;
        n_checks++; if (to_flag !== 1'b1) $display("FAIL to_flag got %b exp 1", to_flag); else n_pass++;
        n_checks++; if (to_idx !== 1'b0) $display("FAIL to_idx got %b exp 0", to_idx); else n_pass++;
        n_checks++; if (gnt !== 2'b01) $display("FAIL to_abort_gnt got %b exp 01", gnt); else n_pass++;
        tick();
        n_checks++; if (to_err !== 1'b0) $display("FAIL to_err_pulse got %b exp 0", to_err); else n_pass++;
        n_checks++; if (gnt !== 2'b01) $display("FAIL to_wait_gnt got %b exp 01", gnt); else n_pass++;
        ack_i = 1'b1;
        tick();
        n_checks++; if (tgt_en !== 1'b0) $display("FAIL to_late_ack_tgt_en got %b exp 0", tgt_en); else n_pass++;
        n_checks++; if (gnt !== 2'b01) $display("FAIL to_late_ack_gnt got %b exp 01", gnt); else n_pass++;
        ack_i = 1'b0; req = 2'b00; cyc_i = 2'b00;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL to_release_gnt got %b exp 00", gnt); else n_pass++;
    endtask

    task automatic test_clear();
        to_clr = 1'b1;
        tick();
        n_checks++; if (to_flag !== 1'b0) $display("FAIL clr_flag got %b exp 0", to_flag); else n_pass++;
        n_checks++; if (to_idx !== 1'b0) $display("FAIL clr_to_idx got %b exp 0", to_idx); else n_pass++;
        to_clr = 1'b0;
    endtask

    task automatic test_ack_boundary();
        req = 2'b10; cyc_i = 2'b10;
        tick();
        n_checks++; if (gnt !== 2'b10) $display("FAIL bnd_gnt got %b exp 10", gnt); else n_pass++;
        for (int k = 1; k <= 7; k++) tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        n_checks++; if (to_err !== 1'b0) $display("FAIL bnd_ack_to_err got %b exp 0", to_err); else n_pass++;
        n_checks++; if (tgt_en !== 1'b1) $display("FAIL bnd_ack_tgt_en got %b exp 1", tgt_en); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++; if (to_err !== 1'b0) $display("FAIL bnd_restart_err[%0d] got %b exp 0", k, to_err); else n_pass++;
        end
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        n_checks++; if (to_err !== 1'b1) $display("FAIL bnd_to_err got %b exp 1", to_err); else n_pass++;
        n_checks++; if (to_flag !== 1'b1) $display("FAIL bnd_set_beats_clr got %b exp 1", to_flag); else n_pass++;
        n_checks++; if (to_idx !== 1'b1) $display("FAIL bnd_to_idx got %b exp 1", to_idx); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL rst_wait_gnt got %b exp 00", gnt); else n_pass++;
        n_checks++; if (tgt_en !== 1'b0) $display("FAIL rst_wait_tgt_en got %b exp 0", tgt_en); else n_pass++;
        n_checks++; if (to_err !== 1'b0) $display("FAIL rst_wait_to_err got %b exp 0", to_err); else n_pass++;
        n_checks++; if (to_flag !== 1'b0) $display("FAIL rst_wait_to_flag got %b exp 0", to_flag); else n_pass++;
        n_checks++; if (to_idx !== 1'b0) $display("FAIL rst_wait_to_idx got %b exp 0", to_idx); else n_pass++;
        reset = 1'b1; req = 2'b10; cyc_i = 2'b10;
        tick();
        n_checks++; if (gnt !== 2'b10) $display("FAIL rst_busy_pre_gnt got %b exp 10", gnt); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (gnt !== 2'b00) $display("FAIL rst_busy_gnt got %b exp 00", gnt); else n_pass++;
        n_checks++; if (tgt_en !== 1'b0) $display("FAIL rst_busy_tgt_en got %b exp 0", tgt_en); else n_pass++;
        n_checks++; if (gnt_idx !== 1'b0) $display("FAIL rst_busy_gnt_idx got %b exp 0", gnt_idx); else n_pass++;
        reset = 1'b1; req = 2'b11; cyc_i = 2'b11;
        tick();
        n_checks++; if (gnt !== 2'b01) $display("FAIL rst_first_gnt got %b exp 01", gnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_fairness();
        test_lock();
        test_timeout();
        test_clear();
        test_ack_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_target_arbiter.md
Name: wb_target_arbiter

Overview:
- Per-target arbiter that shares one Wishbone target port among N initiator ports inside the wishbone interconnect fabric.
- Grants one initiator at a time, round-robin, and locks the grant for the whole bus cycle (cyc held).
- Contains a transaction watchdog: if the target never acks, the arbiter isolates the target and returns a one-cycle error to the owning initiator, so no initiator hangs the fabric.
- One instance per target port; the address decode feeding req is external.

Parameters:
- N_INITIATORS, 2, number of requesting initiator ports (>=1).
- TIMEOUT_CYCLES, 255, cycles without ack/err before abort; 0 disables the watchdog.
- CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  N_INITIATORS  per initiator: cyc&stb&address-hit for this target.
- cyc_i  input  N_INITIATORS  per initiator cyc; holds ownership.
- ack_i  input  1  ack from target.
- err_i  input  1  err from target.
- gnt  output  N_INITIATORS  one-hot owner select for the response mux (registered).
- gnt_idx  output  clog2(N_INITIATORS), min 1  binary index of the current/last owner.
- tgt_en  output  1  forward owner cyc/stb to the target.
- to_err  output  1  one-cycle error strobe to the owner, steered by gnt.
- to_flag  output  1  sticky "timeout occurred".
- to_idx  output  clog2(N_INITIATORS), min 1  owner index at the last timeout.
- to_clr  input  1  clears to_flag; to_idx is unchanged.

Behaviour:
- Reset (reset==0 at the clock edge):
  - State=IDLE.
  - gnt=0, tgt_en=0, to_err=0, to_flag=0, to_idx=0, gnt_idx=0.
  - Round-robin pointer last=N_INITIATORS-1, so initiator 0 wins first.
  - Counter=0.
- IDLE:
  - If any req bit is set, pick the first set bit searching from last+1 upward, wrapping modulo N.
  - Next cycle: gnt=onehot(winner), gnt_idx=winner, tgt_en=1, last=winner, counter=0, state=BUSY.
  - Arbitration latency is exactly one cycle from req to gnt.
- BUSY:
  - gnt and tgt_en are held.
  - If cyc_i[owner]==0: next cycle gnt=0, tgt_en=0, state=IDLE. There is always at least one dead cycle between owners.
  - Else if ack_i|err_i: counter=0.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: next cycle state=ABORT, tgt_en=0, to_err=1, to_flag=1, to_idx=owner.
  - Otherwise counter increments.
  - Precedence: cyc drop > ack/err > timeout. An ack in the same cycle the counter expires prevents the abort.
- ABORT:
  - Lasts exactly one cycle; gnt held so the error reaches the owner.
  - Then to_err=0 and state=WAIT_REL.
- WAIT_REL:
  - gnt held, tgt_en=0; late ack_i/err_i are ignored.
  - When cyc_i[owner]==0: gnt=0, state=IDLE.
  - If the owner immediately re-requests, it is still subject to round-robin (last=owner).
- req bits of non-owners are ignored outside IDLE; no preemption.
- to_clr:
  - Clears to_flag on the next edge.
  - If the clear coincides with a new timeout being set, the set wins.
- Counter:
  - Unsigned, CNT_WIDTH bits.
  - Never wraps: it cannot pass TIMEOUT_CYCLES-1 in BUSY.
  - When the watchdog is disabled it saturates at all-ones.
- Reset mid-transaction: all outputs drop to reset values on the next edge regardless of state; the in-flight transfer is abandoned without to_err.

Test Plan:
- Config: N=2, TIMEOUT=8. reset low 2 cycles, then high; assert req=2'b11 -> one cycle later gnt=2'b01, gnt_idx=0, tgt_en=1.
- Fairness: owner 0 drops cyc; req=2'b11 held -> one cycle gnt=0, then gnt=2'b10. Repeat the release -> next gnt=2'b01 (strict alternation).
- Lock: while owner 0 holds cyc for 20 cycles, acking every 3 cycles, with req[1]=1 -> gnt stays 2'b01, no to_err.
- Timeout: owner 0 held, no ack.
  - 8th cycle after grant: to_err=1 for exactly 1 cycle; tgt_en=0; to_flag=1, to_idx=0.
  - gnt remains 2'b01 until cyc_i[0]=0, then IDLE.
- Boundary: ack_i arrives on the cycle the counter reaches 7 -> no abort, counter=0. to_clr with to_flag=1 -> to_flag=0 next cycle. to_clr coincident with a new timeout -> to_flag stays 1.
- Reset in BUSY and in WAIT_REL -> next cycle gnt=0, tgt_en=0, to_err=0, to_flag=0; the first grant after reset goes to initiator 0.
